keylock_ctrl: RTL and testbench

KEYLOCK_CTRL -- requirements
Module: keylock_ctrl

---
 rtl/keylock_ctrl.sv | 156 +++++++++++++++
 tb/tb_keylock_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keylock_ctrl.sv
// Digit-entry lock controller: compares a CODE_LEN BCD entry against a programmable
// code, with a tries budget and a timed lockout after too many wrong entries.
module keylock_ctrl #(
  parameter int unsigned CODE_LEN       = 6,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter logic [31:0] DEFAULT_CODE   = 32'h00335256
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       relock,
  input  logic       prog,
  output logic       locked,
  output logic       alarm,
  output logic [1:0] tries_left
);

  localparam int unsigned W          = 4 * CODE_LEN;
  localparam logic [3:0]  CNT_LAST   = 4'(CODE_LEN - 1);
  localparam logic [1:0]  TRIES_INIT = 2'(MAX_TRIES);
  localparam logic [15:0] TIMER_INIT = 16'(LOCKOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, OPEN, PROG, LOCKOUT} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [W-1:0]   r_entry;
  logic [W-1:0]   r_shadow;
  logic [W-1:0]   r_code;
  logic [W-1:0]   w_entry_shift;
  logic [W-1:0]   w_shadow_shift;
  logic           r_entry_bad;
  logic [3:0]     r_cnt;
  logic [15:0]    r_timer;
  logic [1:0]     r_tries;
  logic           r_locked;
  logic           r_alarm;
  logic           r_key_ready;
  logic           w_accept;
  logic           w_last;
  logic           w_digit_bad;
  logic           w_match;

  assign w_accept    = key_valid & r_key_ready;
  assign w_last      = (r_cnt == CNT_LAST);
  assign w_digit_bad = (key > 4'd9);
  // A non-BCD digit anywhere in the entry can never open the lock.
  assign w_match     = !r_entry_bad && (r_entry == r_code);

  generate
    if (CODE_LEN == 1) begin : g_one_digit
      assign w_entry_shift  = key;
      assign w_shadow_shift = key;
    end else begin : g_multi_digit
      assign w_entry_shift  = {r_entry[W-5:0], key};
      assign w_shadow_shift = {r_shadow[W-5:0], key};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, ENTRY: if (w_accept) w_state_next = w_last ? CHECK : ENTRY;
      CHECK:       w_state_next = w_match ? OPEN : ((r_tries == 2'd1) ? LOCKOUT : IDLE);
      OPEN: begin
        if (relock)    w_state_next = IDLE;
        else if (prog) w_state_next = PROG;
      end
      PROG: begin
        if (relock)        w_state_next = IDLE;
        else if (w_accept) w_state_next = (w_digit_bad || w_last) ? OPEN : PROG;
      end
      LOCKOUT:     if (r_timer <= 16'd1) w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_code      <= DEFAULT_CODE[W-1:0];
      r_entry     <= '0;
      r_shadow    <= '0;
      r_entry_bad <= 1'b0;
      r_cnt       <= '0;
      r_timer     <= '0;
      r_tries     <= TRIES_INIT;
      r_locked    <= 1'b1;
      r_alarm     <= 1'b0;
      r_key_ready <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_locked    <= !(w_state_next == OPEN || w_state_next == PROG);
      r_alarm     <= (w_state_next == LOCKOUT);
      r_key_ready <= (w_state_next == IDLE || w_state_next == ENTRY || w_state_next == PROG);
      case (r_state)
        IDLE, ENTRY: begin
          if (w_accept) begin
            r_entry     <= w_entry_shift;
            r_entry_bad <= ((r_state == ENTRY) && r_entry_bad) || w_digit_bad;
            r_cnt       <= w_last ? 4'd0 : r_cnt + 4'd1;
          end
        end
        CHECK: begin
          r_cnt <= '0;
          if (w_match) begin
            r_tries <= TRIES_INIT;
          end else begin
            r_tries <= r_tries - 2'd1;
            if (r_tries == 2'd1) r_timer <= TIMER_INIT;
          end
        end
        OPEN: begin
          r_cnt    <= '0;
          r_shadow <= '0;
        end
        PROG: begin
          if (relock) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            if (w_digit_bad) begin
              r_cnt <= '0;
            end else begin
              r_shadow <= w_shadow_shift;
              if (w_last) begin
                r_code <= w_shadow_shift;
                r_cnt  <= '0;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
        end
        LOCKOUT: begin
          r_cnt <= '0;
          if (r_timer <= 16'd1) begin
            r_timer <= '0;
            r_tries <= TRIES_INIT;
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready  = r_key_ready;
  assign locked     = r_locked;
  assign alarm      = r_alarm;
  assign tries_left = r_tries;

endmodule

// File: tb/tb_keylock_ctrl.sv
// Directed bench for keylock_ctrl: vector table for the basic entry flow plus
// hand-written sequences for lockout, programming, abort and asynchronous reset.
module tb_keylock_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] key;
  logic       key_valid;
  logic       relock;
  logic       prog;
  logic       key_ready;
  logic       locked;
  logic       alarm;
  logic [1:0] tries_left;

  // Single-digit instance whose reset code is non-BCD: exercises the forced mismatch.
  logic [3:0] key_b;
  logic       key_valid_b;
  logic       relock_b;
  logic       prog_b;
  logic       key_ready_b;
  logic       locked_b;
  logic       alarm_b;
  logic [1:0] tries_left_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keylock_ctrl u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .relock     (relock),
    .prog       (prog),
    .locked     (locked),
    .alarm      (alarm),
    .tries_left (tries_left)
  );

  keylock_ctrl #(
    .CODE_LEN       (1),
    .MAX_TRIES      (1),
    .LOCKOUT_CYCLES (3),
    .DEFAULT_CODE   (32'h0000000C)
  ) u_one (
    .clk        (clk),
    .reset_n    (reset_n),
    .key        (key_b),
    .key_valid  (key_valid_b),
    .key_ready  (key_ready_b),
    .relock     (relock_b),
    .prog       (prog_b),
    .locked     (locked_b),
    .alarm      (alarm_b),
    .tries_left (tries_left_b)
  );

  typedef struct {
    logic       v;
    logic [3:0] k;
    logic       rl;
    logic       pg;
    logic       el;
    logic       ea;
    logic       er;
    logic [1:0] et;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(input logic v, input logic [3:0] k, input logic rl, input logic pg,
                              input logic el, input logic ea, input logic er, input logic [1:0] et);
    vec_t r;
    r.v = v; r.k = k; r.rl = rl; r.pg = pg; r.el = el; r.ea = ea; r.er = er; r.et = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic l, input logic a, input logic r, input logic [1:0] t);
    chk({name, ".locked"}, 32'(locked), 32'(l));
    chk({name, ".alarm"}, 32'(alarm), 32'(a));
    chk({name, ".key_ready"}, 32'(key_ready), 32'(r));
    chk({name, ".tries_left"}, 32'(tries_left), 32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    key       = d;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic enter6(input logic [23:0] c);
    for (int i = 0; i < 6; i++) press(c[23 - 4*i -: 4]);
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  initial begin
    int n;
    int rdy_bad;

    vt[0]  = mk(1, 4'd3,  0, 0, 1, 0, 1, 2'd3);
    vt[1]  = mk(1, 4'd3,  0, 0, 1, 0, 1, 2'd3);
    vt[2]  = mk(1, 4'd5,  0, 0, 1, 0, 1, 2'd3);
    vt[3]  = mk(1, 4'd2,  0, 0, 1, 0, 1, 2'd3);
    vt[4]  = mk(1, 4'd5,  0, 0, 1, 0, 1, 2'd3);
    vt[5]  = mk(1, 4'd6,  0, 0, 1, 0, 0, 2'd3);  // CHECK
    vt[6]  = mk(1, 4'd4,  0, 0, 0, 0, 0, 2'd3);  // OPEN, digit ignored
    vt[7]  = mk(1, 4'd1,  0, 0, 0, 0, 0, 2'd3);
    vt[8]  = mk(0, 4'd0,  1, 1, 1, 0, 1, 2'd3);  // relock beats prog
    vt[9]  = mk(0, 4'd0,  0, 1, 1, 0, 1, 2'd3);  // prog ignored in IDLE
    vt[10] = mk(1, 4'd3,  0, 0, 1, 0, 1, 2'd3);
    vt[11] = mk(1, 4'd3,  0, 0, 1, 0, 1, 2'd3);
    vt[12] = mk(1, 4'd5,  0, 0, 1, 0, 1, 2'd3);
    vt[13] = mk(1, 4'd2,  0, 0, 1, 0, 1, 2'd3);
    vt[14] = mk(1, 4'd5,  0, 0, 1, 0, 1, 2'd3);
    vt[15] = mk(1, 4'd12, 0, 0, 1, 0, 0, 2'd3);  // CHECK with non-BCD digit
    vt[16] = mk(0, 4'd0,  0, 0, 1, 0, 1, 2'd2);
    vt[17] = mk(1, 4'd3,  1, 1, 1, 0, 1, 2'd2);  // relock/prog ignored, digit taken

    reset_n = 1'b0; key = '0; key_valid = 1'b0; relock = 1'b0; prog = 1'b0;
    key_b = '0; key_valid_b = 1'b0; relock_b = 1'b0; prog_b = 1'b0;
    tick();
    tick();
    chk_out("reset", 1, 0, 1, 2'd3);
    chk("reset_one.tries_left", 32'(tries_left_b), 32'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      key = vt[i].k; key_valid = vt[i].v; relock = vt[i].rl; prog = vt[i].pg;
      tick();
      chk_out($sformatf("vec%0d", i), vt[i].el, vt[i].ea, vt[i].er, vt[i].et);
    end
    key_valid = 1'b0; relock = 1'b0; prog = 1'b0;
    $display("vector table applied: total=%0d bad=%0d", total, bad);

    // Finish the second wrong entry, then a third one into lockout.
    for (int i = 0; i < 5; i++) press(4'd3);
    tick();
    chk_out("wrong2", 1, 0, 1, 2'd1);
    enter6(24'h999999);
    chk_out("wrong3_check", 1, 0, 0, 2'd1);
    tick();
    chk_out("lockout_entry", 1, 1, 0, 2'd0);
    n = 0; rdy_bad = 0;
    key = 4'd3; key_valid = 1'b1;
    while (alarm === 1'b1 && n < 3000) begin
      if (key_ready !== 1'b0) rdy_bad++;
      n++;
      tick();
    end
    key_valid = 1'b0;
    chk("lockout_cycles", 32'(n), 32'd1000);
    chk("lockout_ready_low", 32'(rdy_bad), 32'd0);
    chk_out("lockout_exit", 1, 0, 1, 2'd3);
    $display("lockout sequence: alarm cycles=%0d", n);

    enter6(24'h335256);
    chk_out("open_latency_check", 1, 0, 0, 2'd3);
    tick();
    chk_out("open_after_lockout", 0, 0, 0, 2'd3);

    // Program 123456, relock, old code fails, new code opens.
    prog = 1'b1;
    tick();
    prog = 1'b0;
    chk_out("prog_entry", 0, 0, 1, 2'd3);
    enter6(24'h123456);
    chk_out("prog_done", 0, 0, 0, 2'd3);
    pulse_relock();
    chk_out("relock_idle", 1, 0, 1, 2'd3);
    enter6(24'h335256);
    tick();
    chk_out("old_code_rejected", 1, 0, 1, 2'd2);
    enter6(24'h123456);
    tick();
    chk_out("new_code_opens", 0, 0, 0, 2'd3);
    $display("program sequence done");

    // Non-BCD digit aborts programming; code stays 123456.
    prog = 1'b1;
    tick();
    prog = 1'b0;
    press(4'd7);
    press(4'd7);
    press(4'd12);
    chk_out("prog_abort_open", 0, 0, 0, 2'd3);
    pulse_relock();
    enter6(24'h123456);
    tick();
    chk_out("code_kept_after_abort", 0, 0, 0, 2'd3);

    // Reset restores the default code; relock mid-PROG (with a digit) discards progress.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    enter6(24'h335256);
    tick();
    chk_out("default_after_reset", 0, 0, 0, 2'd3);
    prog = 1'b1;
    tick();
    prog = 1'b0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    relock = 1'b1;
    press(4'd5);
    relock = 1'b0;
    chk_out("prog_relock_idle", 1, 0, 1, 2'd3);
    enter6(24'h335256);
    tick();
    chk_out("default_still_opens", 0, 0, 0, 2'd3);
    pulse_relock();

    // Asynchronous reset in the middle of a lockout.
    for (int i = 0; i < 3; i++) begin
      enter6(24'h999999);
      tick();
    end
    for (int i = 0; i < 10; i++) tick();
    chk_out("mid_lockout", 1, 1, 0, 2'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_out("async_reset", 1, 0, 1, 2'd3);
    tick();
    reset_n = 1'b1;
    tick();
    chk_out("after_async_reset", 1, 0, 1, 2'd3);
    $display("async reset sequence done");

    // Single-digit instance: non-BCD key never matches even a non-BCD code.
    key_b = 4'd12; key_valid_b = 1'b1;
    tick();
    key_valid_b = 1'b0;
    chk("one_check.key_ready", 32'(key_ready_b), 32'd0);
    chk("one_check.locked", 32'(locked_b), 32'd1);
    tick();
    chk("one_lockout.alarm", 32'(alarm_b), 32'd1);
    chk("one_lockout.tries_left", 32'(tries_left_b), 32'd0);
    n = 0;
    while (alarm_b === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("one_lockout_cycles", 32'(n), 32'd3);
    chk("one_exit.tries_left", 32'(tries_left_b), 32'd1);
    chk("one_exit.key_ready", 32'(key_ready_b), 32'd1);
    $display("single-digit sequence: alarm cycles=%0d", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
